// File: rtl/inference_scheduler.sv
// Inference scheduler: sequences layer passes over timesteps for one inference.
// Each pass is launched with a one-cycle layer_start and closed by a layer_done
// pulse from the control unit. A watchdog bounds the wait for layer_done, abort
// cancels at any point, and done marks normal completion.
//
// Handshake: start is accepted only in IDLE; layer_done is honoured only in
// WAIT; abort is honoured in every state except IDLE and beats layer_done and
// watchdog expiry in the same cycle. All outputs are registered (first_step is
// decoded directly from the registered step_idx).
module inference_scheduler #(
    parameter int NUM_LAYERS = 2,
    parameter int NUM_STEPS  = 25,
    parameter int IN_ROWS    = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       layer_done,
    output logic       layer_start,
    output logic [3:0] layer_idx,
    output logic [7:0] step_idx,
    output logic       first_step,
    output logic [8:0] in_spk_base_addr,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ADVANCE,
        S_FINISH
    } state_t;

    localparam logic [3:0]  LAST_LAYER = 4'(NUM_LAYERS - 1);
    localparam logic [7:0]  LAST_STEP  = 8'(NUM_STEPS - 1);
    localparam logic [8:0]  ROW_STEP   = 9'(IN_ROWS);
    localparam logic [16:0] TIMEOUT_W  = 17'(TIMEOUT);

    state_t      state;
    logic [15:0] wdog;
    logic        wdog_expired;

    // The current WAIT cycle is the TIMEOUT-th one when wdog+1 reaches TIMEOUT.
    assign wdog_expired = (TIMEOUT != 0) && (({1'b0, wdog} + 17'd1) >= TIMEOUT_W);

    // Neurons start from zero potential on the first timestep.
    assign first_step = (step_idx == 8'd0);

    // Scheduler FSM with registered pulses, indices, busy and error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= S_IDLE;
            layer_start      <= 1'b0;
            done             <= 1'b0;
            busy             <= 1'b0;
            timeout_err      <= 1'b0;
            layer_idx        <= 4'd0;
            step_idx         <= 8'd0;
            in_spk_base_addr <= 9'd0;
            wdog             <= 16'd0;
        end else begin
            layer_start <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        layer_idx        <= 4'd0;
                        step_idx         <= 8'd0;
                        in_spk_base_addr <= 9'd0;
                        wdog             <= 16'd0;
                        timeout_err      <= 1'b0;
                        busy             <= 1'b1;
                        state            <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        layer_start <= 1'b1;
                        wdog        <= 16'd0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (layer_done) begin
                        state <= S_ADVANCE;
                    end else if (wdog_expired) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else if (wdog != 16'hFFFF) begin
                        wdog <= wdog + 16'd1;
                    end
                end
                S_ADVANCE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (layer_idx < LAST_LAYER) begin
                        layer_idx <= layer_idx + 4'd1;
                        state     <= S_LAUNCH;
                    end else if (step_idx < LAST_STEP) begin
                        layer_idx        <= 4'd0;
                        step_idx         <= step_idx + 8'd1;
                        in_spk_base_addr <= in_spk_base_addr + ROW_STEP;
                        state            <= S_LAUNCH;
                    end else begin
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    done  <= !abort;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inference_scheduler.sv
// Testbench for inference_scheduler. Two instances: A (2 layers, 3 steps,
// watchdog 16) covers sequencing, latency, abort, timeout and reset; B
// (1 layer, 70 steps, watchdog off) covers the base-address wrap.
// Drivers push expected layer_start/done events (cycle, kind, indices) into a
// queue; a monitor process pops and compares whenever the DUT pulses.
module tb_inference_scheduler;

    localparam int W = 55;  // {cycle[31:0], kind, step[7:0], layer[3:0], addr[8:0], first}

    logic clk;
    logic reset;
    logic start_a, abort_a, layer_done_a;
    logic start_b, abort_b, layer_done_b;

    logic       layer_start_a, first_a, busy_a, done_a, terr_a;
    logic [3:0] layer_a;
    logic [7:0] step_a;
    logic [8:0] addr_a;
    logic       layer_start_b, first_b, busy_b, done_b, terr_b;
    logic [3:0] layer_b;
    logic [7:0] step_b;
    logic [8:0] addr_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];

    inference_scheduler #(.NUM_LAYERS(2), .NUM_STEPS(3), .IN_ROWS(8), .TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .layer_done(layer_done_a),
        .layer_start(layer_start_a), .layer_idx(layer_a), .step_idx(step_a), .first_step(first_a),
        .in_spk_base_addr(addr_a), .busy(busy_a), .done(done_a), .timeout_err(terr_a)
    );

    inference_scheduler #(.NUM_LAYERS(1), .NUM_STEPS(70), .IN_ROWS(8), .TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .layer_done(layer_done_b),
        .layer_start(layer_start_b), .layer_idx(layer_b), .step_idx(step_b), .first_step(first_b),
        .in_spk_base_addr(addr_b), .busy(busy_b), .done(done_b), .timeout_err(terr_b)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_time_limit act=%0d exp=finished", cyc);
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- helpers ----------------
    function automatic logic [W-1:0] pack_ev(input int c, input logic kind, input logic [7:0] s,
                                             input logic [3:0] l, input logic [8:0] a, input logic f);
        return {32'(c), kind, s, l, a, f};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_layer_start"}, 32'(layer_start_a), 0);
        check({tag, "_done"}, 32'(done_a), 0);
        check({tag, "_busy"}, 32'(busy_a), 0);
        check({tag, "_timeout_err"}, 32'(terr_a), 0);
        check({tag, "_layer_idx"}, 32'(layer_a), 0);
        check({tag, "_step_idx"}, 32'(step_a), 0);
        check({tag, "_base_addr"}, 32'(addr_a), 0);
        check({tag, "_first_step"}, 32'(first_a), 1);
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic monitor_step();
        logic [W-1:0] act;
        logic [W-1:0] exp;
        if (layer_start_a || done_a) begin
            act = pack_ev(cyc, done_a, step_a, layer_a, addr_a, first_a);
            checks++;
            if (exp_a_q.size() == 0) begin
                failures++;
                $display("FAIL event_a_unexpected act=%h exp=none", act);
            end else begin
                exp = exp_a_q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL event_a act=%h exp=%h", act, exp);
                end
            end
        end
        if (layer_start_b || done_b) begin
            act = pack_ev(cyc, done_b, step_b, layer_b, addr_b, first_b);
            checks++;
            if (exp_b_q.size() == 0) begin
                failures++;
                $display("FAIL event_b_unexpected act=%h exp=none", act);
            end else begin
                exp = exp_b_q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL event_b act=%h exp=%h", act, exp);
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    // start accepted at the next edge; first layer_start two cycles after drive.
    task automatic pulse_start_a();
        start_a = 1'b1;
        exp_a_q.push_back(pack_ev(cyc + 2, 1'b0, 8'd0, 4'd0, 9'd0, 1'b1));
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_ls_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (layer_start_a) begin
                ok = 1'b1;
                return;
            end
        end
        check("wait_layer_start_a", 0, 1);
    endtask

    task automatic wait_ls_b(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (layer_start_b) begin
                ok = 1'b1;
                return;
            end
        end
        check("wait_layer_start_b", 0, 1);
    endtask

    // Full inference on A. stop_kind: 0 none, 1 abort with layer_done, 2 reset mid-WAIT.
    task automatic run_a(input int stop_at, input int stop_kind);
        int  s, ns, nl;
        bit  ok;
        pulse_start_a();
        for (int i = 0; i < 6; i++) begin
            s = i / 2;
            wait_ls_a(ok);
            tick();
            if (i == 2) start_a = 1'b1;  // start while busy must be ignored
            tick();
            start_a = 1'b0;
            repeat (3) tick();
            if (i == stop_at) begin
                if (stop_kind == 1) begin
                    layer_done_a = 1'b1;
                    abort_a = 1'b1;
                end else begin
                    reset = 1'b0;
                end
                tick();
                layer_done_a = 1'b0;
                abort_a = 1'b0;
                reset = 1'b1;
                if (stop_kind == 1) begin
                    check("abort_busy", 32'(busy_a), 0);
                    check("abort_done", 32'(done_a), 0);
                    check("abort_layer_start", 32'(layer_start_a), 0);
                end else begin
                    check_reset_a("mid_reset");
                end
                repeat (8) tick();
                check("stop_no_more_events", 32'(exp_a_q.size()), 0);
                check("stop_busy_after", 32'(busy_a), 0);
                return;
            end
            if (i % 2 == 0) begin
                ns = s;
                nl = 1;
            end else begin
                ns = s + 1;
                nl = 0;
            end
            if (i == 5)
                exp_a_q.push_back(pack_ev(cyc + 3, 1'b1, 8'd2, 4'd1, 9'd16, 1'b0));
            else
                exp_a_q.push_back(pack_ev(cyc + 3, 1'b0, 8'(ns), 4'(nl), 9'(ns * 8), ns == 0));
            layer_done_a = 1'b1;
            tick();
            layer_done_a = 1'b0;
        end
        repeat (6) tick();
        check("run_busy_after", 32'(busy_a), 0);
        check("run_all_events_seen", 32'(exp_a_q.size()), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        reset = 1'b0;
        start_a = 1'b1;  // reset must win over start
        abort_a = 1'b0;
        layer_done_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        layer_done_b = 1'b0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) tick();
        check_reset_a("reset");
        check("reset_b_busy", 32'(busy_b), 0);
        check("reset_b_first", 32'(first_b), 1);
        start_a = 1'b0;
        reset = 1'b1;
        repeat (2) tick();

        // Full inference: 6 passes, stray start ignored mid-run, one done.
        run_a(-1, 0);

        // Abort coinciding with layer_done during step 1.
        run_a(2, 1);

        // Watchdog: layer_done withheld.
        pulse_start_a();
        wait_ls_a(ok);
        check("to_err_first_wait", 32'(terr_a), 0);
        repeat (15) tick();
        check("to_busy_at_16th_wait", 32'(busy_a), 1);
        check("to_err_at_16th_wait", 32'(terr_a), 0);
        tick();
        check("to_err_set", 32'(terr_a), 1);
        check("to_busy_cleared", 32'(busy_a), 0);
        check("to_no_done", 32'(done_a), 0);
        repeat (3) tick();
        layer_done_a = 1'b1;  // stray layer_done in IDLE
        abort_a = 1'b1;       // abort in IDLE has no effect
        tick();
        layer_done_a = 1'b0;
        abort_a = 1'b0;
        repeat (3) tick();
        check("to_err_sticky", 32'(terr_a), 1);
        check("stray_busy", 32'(busy_a), 0);
        check("stray_no_events", 32'(exp_a_q.size()), 0);
        start_a = 1'b1;
        abort_a = 1'b1;  // simultaneous with start in IDLE: start wins
        exp_a_q.push_back(pack_ev(cyc + 2, 1'b0, 8'd0, 4'd0, 9'd0, 1'b1));
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        check("to_err_cleared_by_start", 32'(terr_a), 0);
        check("start_abort_busy", 32'(busy_a), 1);
        wait_ls_a(ok);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort_wait_busy", 32'(busy_a), 0);
        repeat (4) tick();

        // Reset mid-WAIT at step 1, layer 1.
        run_a(3, 2);

        // Base address wrap on B: 70 steps of 8 rows.
        start_b = 1'b1;
        exp_b_q.push_back(pack_ev(cyc + 2, 1'b0, 8'd0, 4'd0, 9'd0, 1'b1));
        tick();
        start_b = 1'b0;
        for (int s = 0; s < 70; s++) begin
            wait_ls_b(ok);
            if (s == 63) check("wrap_addr_step63", 32'(addr_b), 504);
            if (s == 64) check("wrap_addr_step64", 32'(addr_b), 0);
            if (s == 69)
                exp_b_q.push_back(pack_ev(cyc + 3, 1'b1, 8'd69, 4'd0, 9'd40, 1'b0));
            else
                exp_b_q.push_back(pack_ev(cyc + 3, 1'b0, 8'(s + 1), 4'd0,
                                          9'(((s + 1) * 8) % 512), 1'b0));
            layer_done_b = 1'b1;
            tick();
            layer_done_b = 1'b0;
        end
        repeat (6) tick();
        check("b_busy_after", 32'(busy_b), 0);
        check("b_all_events_seen", 32'(exp_b_q.size()), 0);
        check("b_no_timeout_err", 32'(terr_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
